ccff_loader: RTL and testbench
==============================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 58, sets the number of configuration bits in the target ccff chain (range 1..65535).
REQ-002 Parameter WORD_W, default 32, sets the width of host data words (range 1..64).
REQ-003 prog_clk  input  1  sole clock; the target chain shifts on its rising edge.
REQ-004 pReset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 abort  input  1  single-cycle request to terminate the load in progress.
REQ-007 cfg_data  input  WORD_W  configuration word from the host.
REQ-008 cfg_valid  input  1  cfg_data is valid.
REQ-009 cfg_ready  output  1  loader accepts cfg_data in this cycle.
REQ-010 ccff_head  output  1  serial bit driven into the chain head.
REQ-011 ccff_en  output  1  shift enable; the chain shifts only on edges where ccff_en=1 (clock-gate enable).
REQ-012 ccff_tail  input  1  serial bit returned from the chain tail.
REQ-013 busy  output  1  load (or verify) in progress.
REQ-014 done  output  1  one-cycle pulse when the operation completes.
REQ-015 error  output  1  verify mismatch flag (only with CCFF_READBACK_EN; tied 0 otherwise).

Function
REQ-016 States are IDLE, LOAD, VERIFY and DONE; VERIFY exists only with CCFF_READBACK_EN.
REQ-017 IDLE->LOAD on start=1; start in any other state is ignored.
REQ-018 Words needed: NW = ceil(CHAIN_LEN/WORD_W); the last word uses only its low (CHAIN_LEN - (NW-1)*WORD_W) bits, and upper bits are discarded.
REQ-019 Each word shifts out LSB first, one bit per cycle; the first bit shifted ends up at the chain tail end.
REQ-020 A word transfers on cfg_valid & cfg_ready; in LOAD, cfg_ready=1 when the bit buffer is empty or is shifting its last bit and words remain; otherwise cfg_ready=0.
REQ-021 ccff_head and ccff_en are registered; ccff_en=1 exactly in cycles where ccff_head carries a payload bit, so the first bit appears the cycle after acceptance.
REQ-022 With no valid data, ccff_en=0 and the chain holds its contents; stalls insert no bits.
REQ-023 A bit counter runs 0..CHAIN_LEN-1; when CHAIN_LEN bits have been enabled, LOAD->DONE (or ->VERIFY), cfg_ready=0.
REQ-024 DONE asserts done for one cycle, then IDLE; busy=1 in LOAD, VERIFY and DONE.
REQ-025 abort in LOAD/VERIFY: next cycle IDLE, ccff_en=0, cfg_ready=0, no done; the chain content is undefined.
REQ-026 If start and abort occur in the same cycle in IDLE, the loader stays IDLE.

Reset
REQ-027 pReset_n=0 forces state IDLE, counters 0, and cfg_ready, ccff_head, ccff_en, busy, done, error to 0, asynchronously.
REQ-028 Reset release is synchronized internally; the first start is honoured no earlier than the second prog_clk edge after deassertion.
REQ-029 Reset mid-load leaves the chain content undefined; the host must restart.

Configuration
REQ-030 Macro CCFF_READBACK_EN, when defined, compiles in the VERIFY state and CRC-16-CCITT (poly 0x1021, init 0xFFFF) signature logic.
REQ-031 With the macro defined, the CRC accumulates every enabled ccff_head bit in LOAD.
REQ-032 In VERIFY, the loader drives ccff_head=ccff_tail with ccff_en=1 for CHAIN_LEN cycles, recirculating and restoring the chain, while a second CRC accumulates ccff_tail.
REQ-033 At the end of VERIFY, error=1 if the CRCs differ, else 0; error holds until the next start or reset.
REQ-034 Without the macro, LOAD goes directly to DONE, error is constant 0, and no CRC logic exists.

Verification
REQ-035 CHAIN_LEN=58, WORD_W=32, words 0xA5A5A5A5 and 0x3FFFFFFF both valid continuously -> 58 consecutive ccff_en cycles, no bubble, bit 0 of 0xA5A5A5A5 first, done pulses once, second word bits 26..31 discarded.
REQ-036 Same data with cfg_valid low for 5 cycles between words -> ccff_en low exactly 5 cycles, chain model holds the identical 58-bit image.
REQ-037 abort asserted at bit 20 -> IDLE next cycle, busy=0, ccff_en=0, no done; subsequent start performs a full 58-bit load.
REQ-038 With CCFF_READBACK_EN, loopback chain model -> 116 ccff_en cycles, error=0, chain image unchanged after VERIFY.
REQ-039 With CCFF_READBACK_EN, chain model bit 17 stuck-at-0 and a pattern with bit 17=1 -> error=1 after done.
REQ-040 pReset_n pulsed low mid-LOAD -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/ccff_loader_if.sv
// rtl/ccff_loader_if.sv - host configuration word stream into ccff_loader
interface ccff_loader_if #(
   parameter int WORD_W = 32
) ();
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - serialises host words into a ccff chain, LSB first
// CCFF_READBACK_EN adds a recirculating VERIFY pass with CRC-16-CCITT compare.
module ccff_loader #(
   parameter int CHAIN_LEN = 58,
   parameter int WORD_W    = 32
) (
   input  logic         prog_clk,
   input  logic         pReset_n,
   input  logic         start,
   input  logic         abort,
   ccff_loader_if.slave cfg,
   output logic         ccff_head,
   output logic         ccff_en,
   input  logic         ccff_tail,
   output logic         busy,
   output logic         done,
   output logic         error
);
   localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
   localparam int CW        = $clog2(WORD_W + 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(WORD_W - 1);
   localparam logic [CW-1:0] LAST_M1 = CW'(LAST_BITS - 1);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [16:0]   NW_C    = 17'(NW);
   localparam logic [16:0]   LEN_C   = 17'(CHAIN_LEN);

   typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

   state_t            state;
   logic [1:0]        rst_sync;
   logic [WORD_W-1:0] bit_buf;
   logic [CW-1:0]     buf_cnt;
   logic [16:0]       words_left;
   logic [16:0]       bit_cnt;
   logic              head_q;
   logic              take;
   logic              next_bit;

   // bit_buf holds the bits still to be driven after the one now on ccff_head
   assign cfg.cfg_ready = (state == LOAD) && (buf_cnt == '0) && (words_left != '0);
   assign take          = cfg.cfg_valid && cfg.cfg_ready;
   assign next_bit      = (buf_cnt != '0) ? bit_buf[0] : cfg.cfg_data[0];
   assign busy          = (state != IDLE);

`ifdef CCFF_READBACK_EN
   logic [15:0] crc_load;
   logic [15:0] crc_chk;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      crc_step = {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
   endfunction

   // during VERIFY the tail is looped straight back so the chain ends up restored
   assign ccff_head = (state == VERIFY) ? ccff_tail : head_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
   assign ccff_head   = head_q;
   assign error       = 1'b0;
`endif

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state      <= IDLE;
         rst_sync   <= 2'b00;
         bit_buf    <= '0;
         buf_cnt    <= '0;
         words_left <= '0;
         bit_cnt    <= '0;
         head_q     <= 1'b0;
         ccff_en    <= 1'b0;
         done       <= 1'b0;
`ifdef CCFF_READBACK_EN
         error      <= 1'b0;
         crc_load   <= 16'hFFFF;
         crc_chk    <= 16'hFFFF;
`endif
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
         done     <= 1'b0;
         case (state)
            IDLE: begin
               ccff_en <= 1'b0;
               if (start && !abort && rst_sync[1]) begin
                  state      <= LOAD;
                  words_left <= NW_C;
                  bit_cnt    <= '0;
                  buf_cnt    <= '0;
`ifdef CCFF_READBACK_EN
                  error      <= 1'b0;
                  crc_load   <= 16'hFFFF;
                  crc_chk    <= 16'hFFFF;
`endif
               end
            end
            LOAD: begin
               if (abort) begin
                  state   <= IDLE;
                  ccff_en <= 1'b0;
               end else if (bit_cnt == LEN_C) begin
                  bit_cnt <= '0;
`ifdef CCFF_READBACK_EN
                  state   <= VERIFY;
                  ccff_en <= 1'b1;
`else
                  state   <= DONE;
                  ccff_en <= 1'b0;
                  done    <= 1'b1;
`endif
               end else if (buf_cnt != '0 || take) begin
                  head_q  <= next_bit;
                  ccff_en <= 1'b1;
                  bit_cnt <= bit_cnt + 17'd1;
`ifdef CCFF_READBACK_EN
                  crc_load <= crc_step(crc_load, next_bit);
`endif
                  if (buf_cnt != '0) begin
                     bit_buf <= bit_buf >> 1;
                     buf_cnt <= buf_cnt - ONE_C;
                  end else begin
                     bit_buf    <= cfg.cfg_data >> 1;
                     buf_cnt    <= (words_left == 17'd1) ? LAST_M1 : FULL_M1;
                     words_left <= words_left - 17'd1;
                  end
               end else begin
                  ccff_en <= 1'b0;
               end
            end
`ifdef CCFF_READBACK_EN
            VERIFY: begin
               if (abort) begin
                  state   <= IDLE;
                  ccff_en <= 1'b0;
               end else begin
                  crc_chk <= crc_step(crc_chk, ccff_tail);
                  bit_cnt <= bit_cnt + 17'd1;
                  if (bit_cnt == LEN_C - 17'd1) begin
                     state   <= DONE;
                     ccff_en <= 1'b0;
                     done    <= 1'b1;
                     error   <= (crc_step(crc_chk, ccff_tail) != crc_load);
                  end
               end
            end
`endif
            DONE: begin
               state   <= IDLE;
               ccff_en <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               ccff_en <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - directed bench for ccff_loader with a bit-queue model and chain model
module tb_ccff_loader;
   localparam int CL = 58;
   localparam int WW = 32;
`ifdef CCFF_READBACK_EN
   localparam int EXP_EN = 2 * CL;
`else
   localparam int EXP_EN = CL;
`endif

   logic prog_clk = 1'b0;
   logic pReset_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic ccff_head, ccff_en, ccff_tail, busy, done, error;

   ccff_loader_if #(.WORD_W(WW)) cfg_if ();

   ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .start    (start),
      .abort    (abort),
      .cfg      (cfg_if),
      .ccff_head(ccff_head),
      .ccff_en  (ccff_en),
      .ccff_tail(ccff_tail),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 prog_clk = ~prog_clk;

   // target chain: position 0 is the head end, CL-1 the tail
   logic [CL-1:0] chain = '0;
   logic          stuck = 1'b0;
   assign ccff_tail = chain[CL-1];

   always @(posedge prog_clk) begin
      if (ccff_en) begin
         logic [CL-1:0] nxt;
         nxt = {chain[CL-2:0], ccff_head};
         if (stuck) nxt[17] = 1'b0;
         chain <= nxt;
      end
   end

   int vectors = 0;
   int miscompares = 0;
   int en_cnt = 0;
   int bubbles = 0;
   int done_cnt = 0;
   bit exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge prog_clk) begin
      if (done) done_cnt++;
      if (busy && !ccff_en && en_cnt > 0 && en_cnt < CL) bubbles++;
      if (ccff_en) begin
         en_cnt++;
         if (exp_q.size() > 0) check("head_bit", ccff_head, exp_q.pop_front());
`ifdef CCFF_READBACK_EN
         else check("loopback_head", ccff_head, ccff_tail);
`else
         else check("extra_en", ccff_en, 1'b0);
`endif
      end
   end

   function automatic logic [CL-1:0] image(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
      logic [CL-1:0] p;
      logic [CL-1:0] r;
      p = {w1[CL-WW-1:0], w0};
      for (int i = 0; i < CL; i++) r[CL-1-i] = p[i];
      return r;
   endfunction

   task automatic push_exp(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
      logic [CL-1:0] p;
      p = {w1[CL-WW-1:0], w0};
      exp_q.delete();
      for (int i = 0; i < CL; i++) exp_q.push_back(p[i]);
   endtask

   task automatic tick();
      @(negedge prog_clk);
      #1;
   endtask

   task automatic put_word(input logic [WW-1:0] w, input int gap);
      int n;
      n = 0;
      cfg_if.cfg_valid = 1'b0;
      while (!cfg_if.cfg_ready && n < 200) begin
         tick();
         n++;
      end
      check("ready_seen", n < 200, 1'b1);
      repeat (gap) tick();
      cfg_if.cfg_data  = w;
      cfg_if.cfg_valid = 1'b1;
      tick();
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic begin_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
      push_exp(w0, w1);
      en_cnt  = 0;
      bubbles = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
   endtask

   task automatic run_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input int gap,
                           input logic exp_err);
      int d0, n;
      d0 = done_cnt;
      begin_load(w0, w1);
      put_word(w0, 0);
      put_word(w1, gap);
      n = 0;
      while (!done && n < 400) begin
         tick();
         n++;
      end
      check("done_seen", done, 1'b1);
      check("error_at_done", error, exp_err);
      tick();
      check("done_width", done, 1'b0);
      check("busy_end", busy, 1'b0);
      check("en_count", en_cnt, EXP_EN);
      check("bubbles", bubbles, gap);
      check("done_pulses", done_cnt - d0, 1);
      check("bits_left", exp_q.size(), 0);
      check("error_hold", error, exp_err);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, d0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_data  = '0;
      #12;
      check("reset_outputs", {ccff_en, ccff_head, busy, done, error, cfg_if.cfg_ready}, 6'b0);
      tick();
      pReset_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_too_early", busy, 1'b0);
      tick();
      tick();
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", busy, 1'b0);

      run_load(32'hA5A5A5A5, 32'h3FFFFFFF, 0, 1'b0);
      check("pin_image", chain, {32'hA5A5A5A5, 26'h3FFFFFF});
      run_load(32'hA5A5A5A5, 32'h3FFFFFFF, 5, 1'b0);
      check("pin_image_gap", chain, {32'hA5A5A5A5, 26'h3FFFFFF});
      run_load(32'hDEADBEEF, 32'h12345678, 2, 1'b0);
      check("chain_image3", chain, image(32'hDEADBEEF, 32'h12345678));

      d0 = done_cnt;
      begin_load(32'hA5A5A5A5, 32'h3FFFFFFF);
      put_word(32'hA5A5A5A5, 0);
      n = 0;
      while (en_cnt < 20 && n < 100) begin
         tick();
         n++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_en", ccff_en, 1'b0);
      check("abort_ready", cfg_if.cfg_ready, 1'b0);
      repeat (3) tick();
      check("abort_no_done", done_cnt - d0, 0);
      exp_q.delete();
      run_load(32'h0F0F1234, 32'h2AAAAAAA, 0, 1'b0);
      check("chain_after_abort", chain, image(32'h0F0F1234, 32'h2AAAAAAA));

      d0 = done_cnt;
      begin_load(32'h13579BDF, 32'h02468ACE);
      put_word(32'h13579BDF, 0);
      n = 0;
      while (en_cnt < 10 && n < 100) begin
         tick();
         n++;
      end
      pReset_n = 1'b0;
      #1;
      check("reset_async", {ccff_en, ccff_head, busy, done, error, cfg_if.cfg_ready}, 6'b0);
      tick();
      pReset_n = 1'b1;
      repeat (3) tick();
      check("reset_no_done", done_cnt - d0, 0);
      exp_q.delete();
      run_load(32'h13579BDF, 32'h02468ACE, 1, 1'b0);
      check("chain_after_reset", chain, image(32'h13579BDF, 32'h02468ACE));

`ifdef CCFF_READBACK_EN
      stuck = 1'b1;
      run_load(32'hA5A5A5A5, 32'h3FFFFFFF, 0, 1'b1);
      stuck = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
